// File: rtl/phoenix_test_controller.sv
// phoeniX test-harness controller: core reset sequencing, run watchdog,
// tohost end-of-test detection and post-test data-memory dump.
module phoenix_test_controller #(
  parameter int          ADDRESS_WIDTH  = 12,
  parameter int          RESET_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 833,
  parameter logic [31:0] TOHOST_ADDRESS = 32'h00000FFC,
  parameter logic [31:0] DUMP_BASE      = 32'h0,
  parameter int          DUMP_WORDS     = 1024
) (
  input  logic                     CLK,
  input  logic                     reset,
  output logic                     core_reset,
  input  logic                     store_valid,
  input  logic [31:0]              store_address,
  input  logic [31:0]              store_data,
  output logic                     mem_read_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic [31:0]              mem_read_data,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDRESS_WIDTH-1:0] dump_address,
  output logic [31:0]              dump_data,
  output logic [31:0]              cycle_count,
  output logic                     test_done,
  output logic                     test_pass,
  output logic                     test_timeout,
  output logic [30:0]              exit_code
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int WW = $clog2(DUMP_WORDS + 2);
  localparam int AW = ADDRESS_WIDTH;

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [WW-1:0] WORDS     = WW'(DUMP_WORDS);
  localparam logic [31:0]   TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] BASE_A    = DUMP_BASE[AW-1:0];

  typedef enum logic [1:0] {
    RESET_HOLD,
    RUN,
    DUMP,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0] hold_cnt;
  logic [31:0]   cyc_q;
  logic          pass_q;
  logic          tmo_q;
  logic [30:0]   exit_q;

  logic [WW-1:0] rd_cnt;
  logic [WW-1:0] acc_cnt;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] pend_addr;
  logic          pend;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_data;
  logic          skid_valid;
  logic [AW-1:0] skid_addr;
  logic [31:0]   skid_data;
  logic          dump_fin;

  logic eot;
  logic tmo;
  logic accept;
  logic issue;
  logic last_acc;

  assign eot = (state == RUN) && store_valid
            && (store_address == TOHOST_ADDRESS)
            && store_data[0];
  assign tmo = (state == RUN) && (cyc_q == TO_LAST)
            && !eot;

  assign accept   = out_valid && dump_ready;
  assign last_acc = accept
                 && (acc_cnt == WORDS - WW'(1));
  // Reads wait for the output slot; a word that
  // returns into a stalled slot parks in the skid.
  assign issue = (state == DUMP)
              && (rd_cnt != WORDS)
              && (!out_valid || accept);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RESET_HOLD:
        if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      RUN:
        if (eot || tmo) state_nxt = DUMP;
      DUMP:
        if (dump_fin || (WORDS == '0))
          state_nxt = DONE;
      DONE:
        state_nxt = DONE;
      default:
        state_nxt = RESET_HOLD;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= RESET_HOLD;
      hold_cnt <= '0;
      cyc_q    <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      exit_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == RESET_HOLD)
        hold_cnt <= hold_cnt + HW'(1);
      if (state == RUN && cyc_q != '1)
        cyc_q <= cyc_q + 32'd1;
      if (eot) begin
        exit_q <= store_data[31:1];
        pass_q <= (store_data[31:1] == '0);
      end else if (tmo) begin
        tmo_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_cnt     <= '0;
      acc_cnt    <= '0;
      rd_addr    <= BASE_A;
      pend_addr  <= '0;
      pend       <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
      dump_fin   <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        rd_cnt    <= rd_cnt + WW'(1);
        rd_addr   <= rd_addr + AW'(4);
        pend_addr <= rd_addr;
      end
      if (accept)
        acc_cnt <= acc_cnt + WW'(1);
      if (last_acc)
        dump_fin <= 1'b1;
      if (!out_valid || accept) begin
        skid_valid <= 1'b0;
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_addr  <= skid_addr;
          out_data  <= skid_data;
        end else if (pend) begin
          out_valid <= 1'b1;
          out_addr  <= pend_addr;
          out_data  <= mem_read_data;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (pend) begin
        skid_valid <= 1'b1;
        skid_addr  <= pend_addr;
        skid_data  <= mem_read_data;
      end
    end
  end

  assign core_reset       = (state != RUN);
  assign mem_read_enable  = issue;
  assign mem_read_address = issue ? rd_addr : '0;
  assign dump_valid       = out_valid;
  assign dump_address     = out_addr;
  assign dump_data        = out_data;
  assign cycle_count      = cyc_q;
  assign test_done        = (state == DONE);
  assign test_pass        = pass_q;
  assign test_timeout     = tmo_q;
  assign exit_code        = exit_q;

endmodule
